// File: rtl/sparc_ctl_pkg.sv
// Shared types and constants for the SPARC control unit.
// State codes, ALU opcodes, instruction field values, control bundle.
package sparc_ctl_pkg;

  typedef enum logic [4:0] {
    RST  = 5'd0,
    F0   = 5'd1,
    F1   = 5'd2,
    DEC  = 5'd3,
    EXA  = 5'd4,
    LS0  = 5'd5,
    LD1  = 5'd6,
    LD2  = 5'd7,
    LS1  = 5'd8,
    ST2  = 5'd9,
    BR   = 5'd10,
    CALL = 5'd11,
    UPD  = 5'd12,
    TRAP = 5'd13
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_MEM,
    C_CALL,
    C_BR,
    C_OTHER
  } cls_t;

  localparam logic [5:0] ALU_ADD   = 6'h00;
  localparam logic [5:0] ALU_PASSA = 6'h3D;
  localparam logic [5:0] ALU_PASSB = 6'h3E;

  localparam logic [1:0] FMT_BR   = 2'b00;
  localparam logic [1:0] FMT_CALL = 2'b01;
  localparam logic [1:0] FMT_ALU  = 2'b10;
  localparam logic [1:0] FMT_MEM  = 2'b11;
  localparam logic [2:0] OP2_BICC = 3'b010;

  localparam logic [1:0] TY_BYTE = 2'b00;
  localparam logic [1:0] TY_HALF = 2'b01;
  localparam logic [1:0] TY_WORD = 2'b10;

  typedef struct packed {
    logic       ir_ld;
    logic       mar_ld;
    logic       mdr_ld;
    logic       pc_ld;
    logic       npc_ld;
    logic       fr_ld;
    logic       rf_le;
    logic       mov;
    logic       rw;
    logic [1:0] typ;
    logic [1:0] ma;
    logic [1:0] mb;
    logic [1:0] mnp;
    logic [1:0] mp;
    logic [1:0] msc;
    logic       mc;
    logic       mm;
    logic       mr;
    logic       mop;
    logic       msa;
    logic [5:0] opxx;
  } ctl_t;

  // Load/store size field to RAM access size.
  function automatic logic [1:0] mem_type(
    input logic [1:0] sz
  );
    unique case (sz)
      2'b01:   return TY_BYTE;
      2'b10:   return TY_HALF;
      default: return TY_WORD;
    endcase
  endfunction

endpackage

// File: rtl/sparc_control_unit_if.sv
// Control-unit to datapath signal bundle.
// master = control unit, slave = datapath.
interface sparc_control_unit_if;
  logic [31:0] IR;
  logic        MOC;
  logic        BCOND;
  logic        TCOND;
  logic        IR_Ld;
  logic        MAR_Ld;
  logic        MDR_Ld;
  logic        PC_Ld;
  logic        NPC_Ld;
  logic        FR_Ld;
  logic        RF_Load_Enable;
  logic        MOV;
  logic        RW;
  logic [1:0]  Type;
  logic [1:0]  MA;
  logic [1:0]  MB;
  logic [1:0]  MNP;
  logic [1:0]  MP;
  logic [1:0]  MSc;
  logic        MC;
  logic        MM;
  logic        MR;
  logic        MOP;
  logic        MSa;
  logic [5:0]  OpXX;
  logic [4:0]  State;

  modport master (
    input  IR, MOC, BCOND, TCOND,
    output IR_Ld, MAR_Ld, MDR_Ld, PC_Ld,
    output NPC_Ld, FR_Ld, RF_Load_Enable,
    output MOV, RW, Type,
    output MA, MB, MNP, MP, MSc,
    output MC, MM, MR, MOP, MSa,
    output OpXX, State
  );

  modport slave (
    output IR, MOC, BCOND, TCOND,
    input  IR_Ld, MAR_Ld, MDR_Ld, PC_Ld,
    input  NPC_Ld, FR_Ld, RF_Load_Enable,
    input  MOV, RW, Type,
    input  MA, MB, MNP, MP, MSc,
    input  MC, MM, MR, MOP, MSa,
    input  OpXX, State
  );
endinterface

// File: rtl/sparc_ctl_decode.sv
// Instruction classifier for the control FSM.
// Pure combinational view of the IR fields the sequencer needs.
module sparc_ctl_decode
  import sparc_ctl_pkg::*;
(
  input  logic [31:0] ir,
  output cls_t        cls,
  output logic        store,
  output logic [1:0]  mtype,
  output logic        imm,
  output logic        setcc
);

  logic unused_bits;
  assign unused_bits = ^{ir[29:25], ir[18:14], ir[12:0]};

  assign store = ir[21];
  assign mtype = mem_type(ir[20:19]);
  assign imm   = ir[13];
  assign setcc = ir[23];

  always_comb begin
    cls = C_OTHER;
    unique case (ir[31:30])
      FMT_ALU:  cls = C_ALU;
      FMT_MEM:  cls = C_MEM;
      FMT_CALL: cls = C_CALL;
      default: begin
        if (ir[24:22] == OP2_BICC) cls = C_BR;
      end
    endcase
  end

endmodule

// File: rtl/sparc_control_unit.sv
// Hardwired SPARC sequencer: fetch, decode, execute, PC/nPC update.
// Moore outputs; MOC/TCOND only steer the next state.
module sparc_control_unit
  import sparc_ctl_pkg::*;
#(
  parameter int         MOC_TIMEOUT = 15,
  parameter logic [2:0] TRAP_TT     = 3'b001
)(
  input logic           Clk,
  input logic           Clr_n,
  sparc_control_unit_if.master bus
);

  localparam logic [7:0] TMO = 8'(MOC_TIMEOUT);

  state_t     state;
  state_t     nxt;
  logic [7:0] cnt;
  logic       tmo;
  cls_t       cls;
  logic       store;
  logic       imm;
  logic       setcc;
  logic [1:0] mtype;
  ctl_t       c;

  sparc_ctl_decode u_dec (
    .ir    (bus.IR),
    .cls   (cls),
    .store (store),
    .mtype (mtype),
    .imm   (imm),
    .setcc (setcc)
  );

  // Last allowed wait cycle; MOC in that cycle still wins.
  assign tmo = (cnt >= TMO - 8'd1);

  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state <= RST;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (cnt != TMO) cnt <= cnt + 8'd1;
    end
  end

  always_comb begin
    nxt   = state;
    c     = '0;
    c.typ = TY_WORD;
    c.rw  = 1'b1;
    unique case (state)
      RST: begin
        nxt      = F0;
        c.pc_ld  = 1'b1;
        c.npc_ld = 1'b1;
        c.mnp    = 2'b11;
        c.mr     = 1'b1;
      end
      F0: begin
        nxt      = F1;
        c.mar_ld = 1'b1;
        c.mb     = 2'b10;
        c.mop    = 1'b1;
        c.opxx   = ALU_PASSB;
      end
      F1: begin
        c.mov   = 1'b1;
        c.ir_ld = 1'b1;
        if (bus.MOC) nxt = DEC;
        else if (tmo) nxt = TRAP;
      end
      DEC: begin
        unique case (cls)
          C_ALU:   nxt = EXA;
          C_MEM:   nxt = LS0;
          C_CALL:  nxt = CALL;
          C_BR:    nxt = BR;
          default: nxt = UPD;
        endcase
        if (bus.TCOND) nxt = TRAP;
      end
      EXA: begin
        nxt     = UPD;
        c.rf_le = 1'b1;
        c.mb    = imm ? 2'b01 : 2'b00;
        c.fr_ld = setcc;
      end
      LS0: begin
        nxt      = store ? LS1 : LD1;
        c.mar_ld = 1'b1;
        c.mb     = imm ? 2'b01 : 2'b00;
        c.mop    = 1'b1;
        c.opxx   = ALU_ADD;
      end
      LD1: begin
        c.mov    = 1'b1;
        c.typ    = mtype;
        c.mdr_ld = 1'b1;
        if (bus.MOC) nxt = LD2;
        else if (tmo) nxt = TRAP;
      end
      LD2: begin
        nxt     = UPD;
        c.mb    = 2'b11;
        c.mop   = 1'b1;
        c.opxx  = ALU_PASSB;
        c.rf_le = 1'b1;
      end
      LS1: begin
        nxt      = ST2;
        c.msa    = 1'b1;
        c.mop    = 1'b1;
        c.opxx   = ALU_PASSA;
        c.mm     = 1'b1;
        c.mdr_ld = 1'b1;
      end
      ST2: begin
        c.mov = 1'b1;
        c.rw  = 1'b0;
        c.typ = mtype;
        if (bus.MOC) nxt = UPD;
        else if (tmo) nxt = TRAP;
      end
      BR: begin
        nxt      = F0;
        c.pc_ld  = 1'b1;
        c.mp     = 2'b11;
        c.npc_ld = 1'b1;
        c.mnp    = bus.BCOND ? 2'b10 : 2'b11;
      end
      CALL: begin
        nxt      = F0;
        c.msc    = 2'b01;
        c.mb     = 2'b10;
        c.mop    = 1'b1;
        c.opxx   = ALU_PASSB;
        c.rf_le  = 1'b1;
        c.pc_ld  = 1'b1;
        c.mp     = 2'b11;
        c.npc_ld = 1'b1;
        c.mnp    = 2'b10;
      end
      UPD: begin
        nxt      = F0;
        c.pc_ld  = 1'b1;
        c.mp     = 2'b11;
        c.npc_ld = 1'b1;
        c.mnp    = 2'b11;
      end
      TRAP: begin
        nxt      = F0;
        c.pc_ld  = 1'b1;
        c.mp     = 2'b01;
        c.npc_ld = 1'b1;
        c.mnp    = 2'b11;
        c.opxx   = {3'b000, TRAP_TT};
      end
      default: nxt = RST;
    endcase
    // Held in reset: quiet bus, any access is dropped at once.
    if (!Clr_n) begin
      c     = '0;
      c.typ = TY_WORD;
      c.rw  = 1'b1;
    end
  end

  assign bus.IR_Ld          = c.ir_ld;
  assign bus.MAR_Ld         = c.mar_ld;
  assign bus.MDR_Ld         = c.mdr_ld;
  assign bus.PC_Ld          = c.pc_ld;
  assign bus.NPC_Ld         = c.npc_ld;
  assign bus.FR_Ld          = c.fr_ld;
  assign bus.RF_Load_Enable = c.rf_le;
  assign bus.MOV            = c.mov;
  assign bus.RW             = c.rw;
  assign bus.Type           = c.typ;
  assign bus.MA             = c.ma;
  assign bus.MB             = c.mb;
  assign bus.MNP            = c.mnp;
  assign bus.MP             = c.mp;
  assign bus.MSc            = c.msc;
  assign bus.MC             = c.mc;
  assign bus.MM             = c.mm;
  assign bus.MR             = c.mr;
  assign bus.MOP            = c.mop;
  assign bus.MSa            = c.msa;
  assign bus.OpXX           = c.opxx;
  assign bus.State          = state;

endmodule

// File: tb/tb_sparc_control_unit.sv
// Randomized bench: per-instruction trace model vs. control unit.
// Each planned instruction expands into its expected state/output steps.
module tb_sparc_control_unit;
  import sparc_ctl_pkg::*;

  logic Clk   = 1'b0;
  logic Clr_n = 1'b0;

  sparc_control_unit_if bus();

  sparc_control_unit #(
    .MOC_TIMEOUT (15),
    .TRAP_TT     (3'b001)
  ) dut (
    .Clk   (Clk),
    .Clr_n (Clr_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       ir_ld, mar_ld, mdr_ld, pc_ld;
    logic       npc_ld, fr_ld, rf_le, mov, rw;
    logic [1:0] typ, ma, mb, mnp, mp, msc;
    logic       mc, mm, mr, mop, msa;
    logic [5:0] op;
  } obs_t;

  typedef struct {
    state_t      st;
    logic [31:0] ir;
    logic        moc;
    logic        bc;
    logic        tc;
  } step_t;

  step_t  q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  state_t prev_st = RST;
  int     wait_len = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic obs_t idle();
    obs_t o;
    o     = '0;
    o.typ = 2'b10;
    o.rw  = 1'b1;
    return o;
  endfunction

  function automatic logic [1:0] size_of(logic [31:0] ir);
    case (ir[20:19])
      2'b00:   return 2'b10;
      2'b01:   return 2'b00;
      2'b10:   return 2'b01;
      default: return 2'b10;
    endcase
  endfunction

  // What the datapath must see in each state, from the control table.
  function automatic obs_t expect_out(state_t s, logic [31:0] ir, logic bc);
    obs_t o;
    o = idle();
    case (s)
      RST:  begin o.pc_ld = 1; o.npc_ld = 1; o.mnp = 2'b11; o.mr = 1; end
      F0:   begin o.mar_ld = 1; o.mb = 2'b10; o.mop = 1; o.op = 6'h3E; end
      F1:   begin o.mov = 1; o.ir_ld = 1; end
      EXA:  begin
        o.rf_le = 1; o.fr_ld = ir[23];
        o.mb = ir[13] ? 2'b01 : 2'b00;
      end
      LS0:  begin
        o.mar_ld = 1; o.mop = 1; o.op = 6'h00;
        o.mb = ir[13] ? 2'b01 : 2'b00;
      end
      LD1:  begin o.mov = 1; o.mdr_ld = 1; o.typ = size_of(ir); end
      LD2:  begin o.mb = 2'b11; o.mop = 1; o.op = 6'h3E; o.rf_le = 1; end
      LS1:  begin o.msa = 1; o.mop = 1; o.op = 6'h3D; o.mm = 1; o.mdr_ld = 1; end
      ST2:  begin o.mov = 1; o.rw = 0; o.typ = size_of(ir); end
      BR:   begin
        o.pc_ld = 1; o.mp = 2'b11; o.npc_ld = 1;
        o.mnp = bc ? 2'b10 : 2'b11;
      end
      CALL: begin
        o.msc = 2'b01; o.mb = 2'b10; o.mop = 1; o.op = 6'h3E; o.rf_le = 1;
        o.pc_ld = 1; o.mp = 2'b11; o.npc_ld = 1; o.mnp = 2'b10;
      end
      UPD:  begin o.pc_ld = 1; o.mp = 2'b11; o.npc_ld = 1; o.mnp = 2'b11; end
      TRAP: begin
        o.pc_ld = 1; o.mp = 2'b01; o.npc_ld = 1; o.mnp = 2'b11; o.op = 6'h01;
      end
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.ir_ld  = bus.IR_Ld;
    o.mar_ld = bus.MAR_Ld;
    o.mdr_ld = bus.MDR_Ld;
    o.pc_ld  = bus.PC_Ld;
    o.npc_ld = bus.NPC_Ld;
    o.fr_ld  = bus.FR_Ld;
    o.rf_le  = bus.RF_Load_Enable;
    o.mov    = bus.MOV;
    o.rw     = bus.RW;
    o.typ    = bus.Type;
    o.ma     = bus.MA;
    o.mb     = bus.MB;
    o.mnp    = bus.MNP;
    o.mp     = bus.MP;
    o.msc    = bus.MSc;
    o.mc     = bus.MC;
    o.mm     = bus.MM;
    o.mr     = bus.MR;
    o.mop    = bus.MOP;
    o.msa    = bus.MSa;
    o.op     = bus.OpXX;
    return o;
  endfunction

  task automatic push(state_t st, logic [31:0] ir, logic moc, logic bc, logic tc);
    step_t s;
    s.st = st; s.ir = ir; s.moc = moc; s.bc = bc; s.tc = tc;
    q.push_back(s);
  endtask

  // Wait of d cycles for MOC; beyond 15 the access times out.
  task automatic wait_phase(state_t st, logic [31:0] ir, int d, output logic ok);
    int n;
    n = (d <= 15) ? d : 15;
    for (int i = 1; i <= n; i++)
      push(st, ir, (d <= 15) && (i == n), 1'($urandom), 1'($urandom));
    ok = (d <= 15);
  endtask

  task automatic plan(logic [31:0] ir, int df, int dm, logic tc, logic bc);
    logic ok;
    push(F0, ir, 1'($urandom), 1'($urandom), 1'($urandom));
    wait_phase(F1, ir, df, ok);
    if (!ok) begin
      push(TRAP, ir, 1'($urandom), 1'($urandom), 1'($urandom));
      return;
    end
    push(DEC, ir, 1'($urandom), 1'($urandom), tc);
    if (tc) begin
      push(TRAP, ir, 1'($urandom), 1'($urandom), 1'($urandom));
      return;
    end
    case (ir[31:30])
      2'b10: begin
        push(EXA, ir, 1'($urandom), 1'($urandom), 1'($urandom));
        push(UPD, ir, 1'($urandom), 1'($urandom), 1'($urandom));
      end
      2'b11: begin
        push(LS0, ir, 1'($urandom), 1'($urandom), 1'($urandom));
        if (ir[21]) begin
          push(LS1, ir, 1'($urandom), 1'($urandom), 1'($urandom));
          wait_phase(ST2, ir, dm, ok);
          push(ok ? UPD : TRAP, ir, 1'($urandom), 1'($urandom), 1'($urandom));
        end else begin
          wait_phase(LD1, ir, dm, ok);
          if (ok) push(LD2, ir, 1'($urandom), 1'($urandom), 1'($urandom));
          push(ok ? UPD : TRAP, ir, 1'($urandom), 1'($urandom), 1'($urandom));
        end
      end
      2'b01: push(CALL, ir, 1'($urandom), 1'($urandom), 1'($urandom));
      default: begin
        if (ir[24:22] == 3'b010) push(BR, ir, 1'($urandom), bc, 1'($urandom));
        else push(UPD, ir, 1'($urandom), 1'($urandom), 1'($urandom));
      end
    endcase
  endtask

  task automatic check_step(step_t s);
    state_t cur;
    chk("state", 64'(bus.State), 64'(s.st));
    chk("outputs", 64'(sample()), 64'(expect_out(s.st, s.ir, s.bc)));
    cur = state_t'(bus.State);
    if (s.st == TRAP) chk("trap_tt", 64'(bus.OpXX), 64'h01);
    if (s.st == BR) chk("br_mnp", 64'(bus.MNP), s.bc ? 64'h2 : 64'h3);
    if (s.ir == 32'hC2282004 && cur == ST2) chk("stb_type", 64'(bus.Type), 64'h0);
    if (s.ir == 32'hC2006008 && cur == LD1) chk("ldw_type", 64'(bus.Type), 64'h2);
    if (s.ir == 32'h82006005 && cur == EXA) chk("add_mb", 64'(bus.MB), 64'h1);
    if (cur == TRAP && (prev_st == F1 || prev_st == LD1 || prev_st == ST2))
      chk("timeout_len", 64'(wait_len), 64'd15);
    if (cur == prev_st) wait_len++;
    else wait_len = 1;
    prev_st = cur;
  endtask

  task automatic run();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge Clk);
      bus.IR    = s.ir;
      bus.MOC   = s.moc;
      bus.BCOND = s.bc;
      bus.TCOND = s.tc;
      #1;
      check_step(s);
    end
  endtask

  task automatic release_reset();
    repeat (2) @(posedge Clk);
    #2 Clr_n = 1'b1;
    prev_st  = RST;
    wait_len = 0;
    push(RST, 32'h0, 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  function automatic logic [31:0] rand_ir();
    logic [31:0] r;
    logic [31:0] ir;
    r = $urandom;
    case ($urandom_range(0, 4))
      0: ir = {2'b10, r[29:0]};
      1: ir = {2'b11, r[29:0]};
      2: ir = {2'b01, r[29:0]};
      3: ir = {2'b00, r[29:25], 3'b010, r[21:0]};
      default: begin
        ir = {2'b00, r[29:0]};
        if (ir[24:22] == 3'b010) ir[22] = 1'b1;
      end
    endcase
    return ir;
  endfunction

  initial begin
    bus.IR = '0; bus.MOC = 0; bus.BCOND = 0; bus.TCOND = 0;
    Clr_n = 1'b0;
    #1;
    chk("rst_state", 64'(bus.State), 64'd0);
    chk("rst_out", 64'(sample()), 64'(idle()));
    release_reset();
    plan(32'h82006005, 2, 1, 0, 0);
    plan(32'hC2006008, 1, 3, 0, 0);
    plan(32'hC2282004, 1, 2, 0, 0);
    plan({2'b00, 5'd8, 3'b010, 22'h10}, 1, 1, 0, 1);
    plan({2'b00, 5'd8, 3'b010, 22'h10}, 1, 1, 0, 0);
    plan(32'h40000004, 1, 1, 0, 0);
    plan(32'h82006005, 20, 1, 0, 0);
    plan(32'hC2006008, 15, 15, 0, 0);
    plan(32'hC2006008, 1, 16, 0, 0);
    plan(32'hC2282004, 1, 30, 0, 0);
    plan(32'h82006005, 1, 1, 1, 0);
    run();

    // Reset dropped in the middle of a load access.
    push(F0, 32'hC2006008, 0, 0, 0);
    push(F1, 32'hC2006008, 1, 0, 0);
    push(DEC, 32'hC2006008, 0, 0, 0);
    push(LS0, 32'hC2006008, 0, 0, 0);
    push(LD1, 32'hC2006008, 0, 0, 0);
    run();
    #2 Clr_n = 1'b0;
    #1;
    chk("midrst_state", 64'(bus.State), 64'd0);
    chk("midrst_mov", 64'(bus.MOV), 64'd0);
    chk("midrst_out", 64'(sample()), 64'(idle()));
    release_reset();
    run();

    repeat (150) begin
      plan(rand_ir(), $urandom_range(1, 17), $urandom_range(1, 17),
           ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
